// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings, record type and helpers for hazard_ctrl
package hazard_ctrl_pkg;

    localparam logic [1:0] KIND_ALU  = 2'd0;
    localparam logic [1:0] KIND_MEM  = 2'd1;
    localparam logic [1:0] KIND_LINK = 2'd2;

    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;
    localparam logic [1:0] TNEW_LINK = 2'd0;

    localparam logic [2:0] SEL_RD     = 3'd0;
    localparam logic [2:0] SEL_MEMRDW = 3'd1;
    localparam logic [2:0] SEL_RESW   = 3'd2;
    localparam logic [2:0] SEL_RESM   = 3'd3;
    localparam logic [2:0] SEL_PC8W   = 3'd4;
    localparam logic [2:0] SEL_PC8M   = 3'd5;
    localparam logic [2:0] SEL_PC8E   = 3'd6;

    typedef enum logic [1:0] {
        STG_E = 2'd0,
        STG_M = 2'd1,
        STG_W = 2'd2
    } stage_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic [1:0] kind;
        logic [1:0] tnew;
    } rec_t;

    // One pipeline advance: the value is one cycle closer to existing.
    function automatic rec_t rec_advance(input rec_t r);
        rec_t n;
        n = r;
        n.tnew = (r.tnew == 2'd0) ? 2'd0 : r.tnew - 2'd1;
        return n;
    endfunction

    function automatic logic producer_hit(input rec_t r, input logic [4:0] src, input logic use_src);
        return r.valid && use_src && (src != 5'd0) && (r.dst == src);
    endfunction

    // Only ready values (tnew == 0) reach here; unlisted stage/kind pairs read the register file.
    function automatic logic [2:0] fwd_sel(input stage_e stg, input logic [1:0] kind);
        logic [2:0] s;
        s = SEL_RD;
        case (stg)
            STG_E: if (kind == KIND_LINK) s = SEL_PC8E;
            STG_M: begin
                if (kind == KIND_ALU)       s = SEL_RESM;
                else if (kind == KIND_LINK) s = SEL_PC8M;
            end
            STG_W: begin
                if (kind == KIND_ALU)       s = SEL_RESW;
                else if (kind == KIND_MEM)  s = SEL_MEMRDW;
                else if (kind == KIND_LINK) s = SEL_PC8W;
            end
            default: s = SEL_RD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - D-stage decode bundle and hazard responses
interface hazard_ctrl_if;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic        useRsD;
    logic        useRtD;
    logic [1:0]  tuseRsD;
    logic [1:0]  tuseRtD;
    logic        wrD;
    logic [4:0]  dstD;
    logic [1:0]  kindD;
    logic [1:0]  tnewD;
    logic        stall;
    logic [2:0]  MCMP1D;
    logic [2:0]  MCMP2D;
    logic [31:0] stallCnt;

    modport master (
        output rsD, rtD, useRsD, useRtD, tuseRsD, tuseRtD, wrD, dstD, kindD, tnewD,
        input  stall, MCMP1D, MCMP2D, stallCnt
    );

    modport slave (
        input  rsD, rtD, useRsD, useRtD, tuseRsD, tuseRtD, wrD, dstD, kindD, tnewD,
        output stall, MCMP1D, MCMP2D, stallCnt
    );
endinterface

// File: rtl/hazard_ctrl_sel.sv
// rtl/hazard_ctrl_sel.sv - per-operand stall and compare-mux select from the E/M/W records
module hazard_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       use_src,
    input  logic [1:0] tuse,
    input  rec_t       rec_e,
    input  rec_t       rec_m,
    input  rec_t       rec_w,
    output logic       stall,
    output logic [2:0] sel
);

    logic   hit_e;
    logic   hit_m;
    logic   hit_w;
    logic   any_hit;
    rec_t   win;
    stage_e win_stage;

    always_comb begin
        hit_e     = producer_hit(rec_e, src, use_src);
        hit_m     = producer_hit(rec_m, src, use_src);
        hit_w     = producer_hit(rec_w, src, use_src);
        win       = '0;
        win_stage = STG_E;
        any_hit   = 1'b1;

        // Youngest producer holds the architecturally current value.
        if (hit_e) begin
            win       = rec_e;
            win_stage = STG_E;
        end else if (hit_m) begin
            win       = rec_m;
            win_stage = STG_M;
        end else if (hit_w) begin
            win       = rec_w;
            win_stage = STG_W;
        end else begin
            any_hit   = 1'b0;
        end

        stall = any_hit && (win.tnew > tuse);
        sel   = (any_hit && (win.tnew == 2'd0)) ? fwd_sel(win_stage, win.kind) : SEL_RD;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: shadow E/M/W records, stall and D-compare forwarding
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    hazard_ctrl_if.slave hz
);

    rec_t        rec_e;
    rec_t        rec_m;
    rec_t        rec_w;
    rec_t        rec_d;
    logic        stall_rs;
    logic        stall_rt;
    logic        stall;
    logic [2:0]  sel_rs;
    logic [2:0]  sel_rt;
    logic [31:0] stall_cnt;

    always_comb begin
        rec_d       = '0;
        rec_d.valid = hz.wrD && (hz.dstD != 5'd0);
        rec_d.dst   = hz.dstD;
        rec_d.kind  = hz.kindD;
        rec_d.tnew  = hz.tnewD;
    end

    hazard_sel u_sel_rs (
        .src     (hz.rsD),
        .use_src (hz.useRsD),
        .tuse    (hz.tuseRsD),
        .rec_e   (rec_e),
        .rec_m   (rec_m),
        .rec_w   (rec_w),
        .stall   (stall_rs),
        .sel     (sel_rs)
    );

    hazard_sel u_sel_rt (
        .src     (hz.rtD),
        .use_src (hz.useRtD),
        .tuse    (hz.tuseRtD),
        .rec_e   (rec_e),
        .rec_m   (rec_m),
        .rec_w   (rec_w),
        .stall   (stall_rt),
        .sel     (sel_rt)
    );

    assign stall = stall_rs | stall_rt;

    // M and W always advance; only E is gated, taking a bubble while D is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_e     <= '0;
            rec_m     <= '0;
            rec_w     <= '0;
            stall_cnt <= 32'd0;
        end else begin
            rec_e <= stall ? rec_t'('0) : rec_d;
            rec_m <= rec_advance(rec_e);
            rec_w <= rec_advance(rec_m);
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign hz.stall    = stall;
    assign hz.MCMP1D   = sel_rs;
    assign hz.MCMP2D   = sel_rt;
    assign hz.stallCnt = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    typedef struct {
        string       name;
        logic        stall;
        logic [2:0]  m1;
        logic [2:0]  m2;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t q[$];

    hazard_ctrl_if hz();

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, ".stall"},    32'(hz.stall),  32'(e.stall));
            chk({e.name, ".mcmp1"},    32'(hz.MCMP1D), 32'(e.m1));
            chk({e.name, ".mcmp2"},    32'(hz.MCMP2D), 32'(e.m2));
            chk({e.name, ".stallcnt"}, hz.stallCnt,    e.cnt);
        end
    end

    task automatic drive(input string name,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt,
                         input logic [1:0] trs, input logic [1:0] trt,
                         input logic wr, input logic [4:0] dst,
                         input logic [1:0] kind, input logic [1:0] tnew,
                         input logic rst,
                         input logic es, input logic [2:0] e1, input logic [2:0] e2,
                         input logic [31:0] ec);
        exp_t e;
        hz.rsD = rs;  hz.rtD = rt;
        hz.useRsD = urs;  hz.useRtD = urt;
        hz.tuseRsD = trs; hz.tuseRtD = trt;
        hz.wrD = wr;  hz.dstD = dst;  hz.kindD = kind;  hz.tnewD = tnew;
        reset = rst;
        e.name = name; e.stall = es; e.m1 = e1; e.m2 = e2; e.cnt = ec;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic prod(input string name, input logic [4:0] dst, input logic [1:0] kind,
                        input logic [1:0] tnew, input logic [31:0] ec);
        drive(name, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, dst, kind, tnew, 1'b0,
              1'b0, SEL_RD, SEL_RD, ec);
    endtask

    task automatic cons(input string name, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] trs, input logic [1:0] trt, input logic rst,
                        input logic es, input logic [2:0] e1, input logic [2:0] e2,
                        input logic [31:0] ec);
        drive(name, rs, rt, 1'b1, 1'b1, trs, trt, 1'b0, 5'd0, KIND_ALU, 2'd0, rst, es, e1, e2, ec);
    endtask

    task automatic do_reset();
        hz.rsD = 5'd0; hz.rtD = 5'd0; hz.useRsD = 1'b0; hz.useRtD = 1'b0;
        hz.tuseRsD = 2'd0; hz.tuseRtD = 2'd0; hz.wrD = 1'b0; hz.dstD = 5'd0;
        hz.kindD = KIND_ALU; hz.tnewD = 2'd0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        do_reset();
        do_reset();

        drive("rst_idle", 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 5'd0, KIND_ALU, 2'd0, 1'b0,
              1'b0, SEL_RD, SEL_RD, 32'd0);

        // ALU producer then compare at tuse 0: one stall, then ResM
        do_reset();
        prod("alu_addu", 5'd1, KIND_ALU, TNEW_ALU, 32'd0);
        cons("alu_beq0", 5'd1, 5'd2, 2'd0, 2'd0, 1'b0, 1'b1, SEL_RD, SEL_RD, 32'd0);
        cons("alu_beq1", 5'd1, 5'd2, 2'd0, 2'd0, 1'b0, 1'b0, SEL_RESM, SEL_RD, 32'd1);

        // Load then compare: two stalls, then MemRDW
        do_reset();
        prod("ld_lw", 5'd3, KIND_MEM, TNEW_LOAD, 32'd0);
        cons("ld_beq0", 5'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b1, SEL_RD, SEL_RD, 32'd0);
        cons("ld_beq1", 5'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b1, SEL_RD, SEL_RD, 32'd1);
        cons("ld_beq2", 5'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, SEL_MEMRDW, SEL_RD, 32'd2);

        // Link value forwarded from E, then M, then W
        do_reset();
        prod("jal", 5'd31, KIND_LINK, TNEW_LINK, 32'd0);
        cons("link_e", 5'd31, 5'd31, 2'd0, 2'd0, 1'b0, 1'b0, SEL_PC8E, SEL_PC8E, 32'd0);
        cons("link_m", 5'd31, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, SEL_PC8M, SEL_RD, 32'd0);
        cons("link_w", 5'd0, 5'd31, 2'd0, 2'd0, 1'b0, 1'b0, SEL_RD, SEL_PC8W, 32'd0);

        // Same dst in D and E is no hazard; M wins over W; then W ALU
        do_reset();
        prod("waw_ori", 5'd5, KIND_ALU, TNEW_ALU, 32'd0);
        prod("waw_addu", 5'd5, KIND_ALU, TNEW_ALU, 32'd0);
        drive("waw_nop", 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 5'd0, KIND_ALU, 2'd0, 1'b0,
              1'b0, SEL_RD, SEL_RD, 32'd0);
        cons("m_over_w", 5'd5, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, SEL_RESM, SEL_RD, 32'd0);
        cons("w_alu", 5'd0, 5'd5, 2'd0, 2'd0, 1'b0, 1'b0, SEL_RD, SEL_RESW, 32'd0);

        // Writes to $0 never match
        do_reset();
        prod("zero_wr", 5'd0, KIND_ALU, TNEW_ALU, 32'd0);
        cons("zero_rd", 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, SEL_RD, SEL_RD, 32'd0);

        // Load with tuse 1: one stall, then 0 < tnew <= tuse gives select 0
        prod("tu_lw", 5'd3, KIND_MEM, TNEW_LOAD, 32'd0);
        cons("tu_use0", 5'd3, 5'd0, 2'd1, 2'd0, 1'b0, 1'b1, SEL_RD, SEL_RD, 32'd0);
        cons("tu_use1", 5'd3, 5'd0, 2'd1, 2'd0, 1'b0, 1'b0, SEL_RD, SEL_RD, 32'd1);

        // Reset during the second load stall
        do_reset();
        prod("rs_lw", 5'd3, KIND_MEM, TNEW_LOAD, 32'd0);
        cons("rs_st0", 5'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b1, SEL_RD, SEL_RD, 32'd0);
        cons("rs_st1", 5'd3, 5'd0, 2'd0, 2'd0, 1'b1, 1'b1, SEL_RD, SEL_RD, 32'd1);
        cons("rs_after", 5'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, SEL_RD, SEL_RD, 32'd0);

        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
